soc_system_pio_irq: RTL and testbench

//   Parametrised Avalon-MM parallel I/O slave for the HPS-to-FPGA bus: the next generation of our 32-bit PIO.

---
 rtl/soc_system_pio_irq.sv | 96 +++++++++
 tb/tb_soc_system_pio_irq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_irq.sv
// Avalon-MM PIO slave: atomic output set/clear, synchronised inputs,
// sticky edge capture with write-1-to-clear, and a maskable level interrupt.
module soc_system_pio_irq #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] sel;
  logic [DATA_WIDTH-1:0] edge_clr;
  logic [2:0]            arm_cnt;
  logic                  armed;
  logic                  wr_en;

  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_cnt == 3'(ARM_MAX));
  assign wr_en    = chipselect & ~write_n;
  assign edge_clr = (wr_en && address == 3'd4) ? writedata : '0;
  assign out_port = out_reg;
  assign irq      = |(edge_capture & irq_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_in;
      // Arming hides the startup transition of the chain from edge capture.
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end
  end

  always_comb begin
    rise = sync_in & ~prev_q;
    fall = ~sync_in & prev_q;
    case (EDGE_MODE)
      1:       sel = fall;
      2:       sel = rise | fall;
      default: sel = rise;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg      <= OUT_RESET;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          3'd0:    out_reg  <= writedata;
          3'd1:    out_reg  <= out_reg | writedata;
          3'd2:    out_reg  <= out_reg & ~writedata;
          3'd3:    irq_mask <= writedata;
          default: ;
        endcase
      end
      // A new edge wins over a simultaneous clear of the same bit.
      edge_capture <= (edge_capture & ~edge_clr) | (sel & {DATA_WIDTH{armed}});
      case (address)
        3'd0:       readdata <= sync_in;
        3'd1, 3'd2: readdata <= out_reg;
        3'd3:       readdata <= irq_mask;
        3'd4:       readdata <= edge_capture;
        default:    readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_pio_irq.sv
// Directed bench for soc_system_pio_irq (32 bits, 2 sync stages, rising edges).
module tb_soc_system_pio_irq;

  localparam logic [31:0] OUT_RST = 32'h0000_0A05;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rv;

  soc_system_pio_irq #(
    .DATA_WIDTH (32),
    .SYNC_STAGES(2),
    .EDGE_MODE  (0),
    .OUT_RESET  (OUT_RST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_port = '1; address = '0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // 1: reset with static-high inputs
    repeat (10) tick();
    check("rst_readdata", readdata, 32'h0);
    check("rst_out_port", out_port, OUT_RST);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    repeat (6) tick();
    rd(3'd4, rv); check("rst_no_false_edge", rv, 32'h0);
    check("rst_irq_after", {31'b0, irq}, 32'h0);
    rd(3'd0, rv); check("rst_data_ones", rv, 32'hFFFF_FFFF);
    rd(3'd1, rv); check("rst_outset_read", rv, OUT_RST);

    // 2: write / set / clear outputs
    wr(3'd0, 32'h0000_00F0); check("out_write", out_port, 32'h0000_00F0);
    wr(3'd1, 32'h0000_000F); check("out_set", out_port, 32'h0000_00FF);
    wr(3'd2, 32'h0000_0030); check("out_clr", out_port, 32'h0000_00CF);
    rd(3'd1, rv); check("outset_read", rv, 32'h0000_00CF);
    rd(3'd2, rv); check("outclr_read", rv, 32'h0000_00CF);

    // 3: rising edge latency, irq, write-1-to-clear
    wr(3'd3, 32'h1);
    in_port = 32'h0;
    repeat (5) tick();
    rd(3'd4, rv); check("falling_ignored", rv, 32'h0);
    rd(3'd0, rv); check("data_zero", rv, 32'h0);
    in_port = 32'h1;
    tick(); check("irq_k", {31'b0, irq}, 32'h0);
    tick(); check("irq_k1", {31'b0, irq}, 32'h0);
    tick(); check("irq_k2", {31'b0, irq}, 32'h1);
    rd(3'd4, rv); check("edge_bit0", rv, 32'h1);
    wr(3'd4, 32'h1); check("irq_cleared", {31'b0, irq}, 32'h0);
    rd(3'd4, rv); check("edge_cleared", rv, 32'h0);

    // 4: set wins over simultaneous clear
    in_port = 32'h9;
    tick();
    tick();
    wr(3'd4, 32'h8);
    rd(3'd4, rv); check("set_wins", rv, 32'h8);
    check("irq_masked_bit3", {31'b0, irq}, 32'h0);
    wr(3'd4, 32'h8);
    rd(3'd4, rv); check("bit3_cleared", rv, 32'h0);

    // 5: masking and unused addresses
    wr(3'd3, 32'h0);
    in_port = 32'hD;
    repeat (4) tick();
    rd(3'd4, rv); check("edge_bit2", rv, 32'h4);
    check("irq_mask0", {31'b0, irq}, 32'h0);
    wr(3'd3, 32'h4); check("irq_unmask", {31'b0, irq}, 32'h1);
    rd(3'd6, rv); check("addr6_zero", rv, 32'h0);
    rd(3'd3, rv); check("mask_read", rv, 32'h4);
    rd(3'd7, rv); check("addr7_zero", rv, 32'h0);

    // 6: reset mid-operation
    wr(3'd4, 32'hFFFF_FFFF);
    rd(3'd4, rv); check("edge_all_clear", rv, 32'h0);
    in_port = 32'h0;
    repeat (4) tick();
    in_port = 32'hFF;
    repeat (4) tick();
    rd(3'd4, rv); check("edge_ff", rv, 32'hFF);
    wr(3'd0, 32'h55); check("out_55", out_port, 32'h55);
    wr(3'd3, 32'hFF); check("irq_ff", {31'b0, irq}, 32'h1);
    reset = 1'b1;
    tick();
    check("mid_rst_out", out_port, OUT_RST);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    check("mid_rst_readdata", readdata, 32'h0);
    reset = 1'b0;
    repeat (6) tick();
    rd(3'd4, rv); check("mid_rst_no_edge", rv, 32'h0);
    rd(3'd3, rv); check("mid_rst_mask", rv, 32'h0);
    rd(3'd1, rv); check("mid_rst_outreg", rv, OUT_RST);
    rd(3'd0, rv); check("mid_rst_data", rv, 32'hFF);
    in_port = 32'h0;
    repeat (4) tick();
    in_port = 32'h80;
    repeat (4) tick();
    rd(3'd4, rv); check("rearmed_edge", rv, 32'h80);
    check("rearmed_irq_masked", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
